// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 9-bit-ISA control sequencer: state encoding, widths,
// the Ack opcode and a saturating increment used by the optional perf counters.
package cpu_sequencer_pkg;
   localparam int          kPcW      = 10;
   localparam int          kInstrW   = 9;
   localparam int          kCntW     = 16;
   localparam logic [8:0]  kAckInstr = 9'h1FF;

   typedef enum logic [2:0] {
      IDLE, FETCH, EXEC, MEM, WB, HALT, ERROR
   } seq_state_t;

   function automatic logic [kCntW-1:0] sat_inc(input logic [kCntW-1:0] v);
      return (v == {kCntW{1'b1}}) ? v : v + kCntW'(1);
   endfunction
endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Clear/enable 8-bit wait counter; expired_o flags that the current cycle is the
// MEM_TIMEOUT-th enabled cycle since the last clear (latency 0, no backpressure).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                         cnt_d = '0;
      else if (en_i && cnt_q != 8'hFF)   cnt_d = cnt_q + 8'd1;
   end

   // cnt_q holds the number of completed wait cycles, so +1 names the current one
   assign expired_o = ({1'b0, cnt_q} + 9'd1) >= 9'(MEM_TIMEOUT);
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer owning PC and IR; ALU 2 cycles, store 3+N, load 4+N.
// Optional perf counters are built only when SEQ_PERF_CNT_EN is defined.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int PC_W        = kPcW,
   parameter int INSTR_W     = kInstrW,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [PC_W-1:0]    StartAddr,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               BranchEn,
   input  logic               Jump,
   input  logic               LoadInst,
   input  logic               MemWrEn,
   input  logic               RegWrEn,
   input  logic               Ack,
   input  logic               CondFlag,
   input  logic [PC_W-1:0]    BrTarget,
   input  logic               MemReady,
   output logic [PC_W-1:0]    ProgCtr,
   output logic [INSTR_W-1:0] IR,
   output logic               RegWrStrobe,
   output logic               MemRdReq,
   output logic               MemWrStrobe,
   output logic               Busy,
   output logic               Done,
   output logic               TimeoutErr,
   output logic [15:0]        InstrCount,
   output logic [15:0]        CycleCount
);
   seq_state_t         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d, pc_next;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               start_ok, mem_expired;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .Clk       (Clk),
      .Reset     (Reset),
      .clr_i     (state_q == EXEC),
      .en_i      (state_q == MEM),
      .expired_o (mem_expired)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   assign start_ok = Start && (state_q == IDLE || state_q == HALT || state_q == ERROR);
   assign pc_next  = (Jump || (BranchEn && CondFlag)) ? BrTarget : pc_q + PC_W'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         IDLE, HALT, ERROR: begin
            if (Start) begin
               pc_d    = StartAddr;
               state_d = FETCH;
            end
         end
         FETCH: begin
            ir_d    = Instruction;
            state_d = EXEC;
         end
         EXEC: begin
            if (Ack)                      state_d = HALT;
            else if (LoadInst || MemWrEn) state_d = MEM;
            else begin
               pc_d    = pc_next;
               state_d = FETCH;
            end
         end
         MEM: begin
            // a completion on the final allowed cycle still wins over the timeout
            if (MemReady) begin
               if (LoadInst) state_d = WB;
               else begin
                  pc_d    = pc_next;
                  state_d = FETCH;
               end
            end else if (mem_expired) begin
               state_d = ERROR;
            end
         end
         WB: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      RegWrStrobe = 1'b0;
      MemRdReq    = 1'b0;
      MemWrStrobe = 1'b0;
      Busy        = 1'b0;
      Done        = 1'b0;
      TimeoutErr  = 1'b0;
      case (state_q)
         FETCH: Busy = 1'b1;
         EXEC: begin
            Busy        = 1'b1;
            RegWrStrobe = RegWrEn && !Ack && !LoadInst && !MemWrEn;
         end
         MEM: begin
            Busy        = 1'b1;
            MemRdReq    = LoadInst;
            MemWrStrobe = MemWrEn;
         end
         WB: begin
            Busy        = 1'b1;
            RegWrStrobe = 1'b1;
         end
         HALT:    Done       = 1'b1;
         ERROR:   TimeoutErr = 1'b1;
         default: ;
      endcase
   end

   assign ProgCtr = pc_q;
   assign IR      = ir_q;

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] icnt_q, icnt_d, ccnt_q, ccnt_d;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         icnt_q <= '0;
         ccnt_q <= '0;
      end else begin
         icnt_q <= icnt_d;
         ccnt_q <= ccnt_d;
      end
   end

   always_comb begin
      icnt_d = icnt_q;
      ccnt_d = ccnt_q;
      if (start_ok) begin
         icnt_d = '0;
         ccnt_d = '0;
      end else begin
         if (state_q == FETCH) icnt_d = sat_inc(icnt_q);
         if (Busy)             ccnt_d = sat_inc(ccnt_q);
      end
   end

   assign InstrCount = icnt_q;
   assign CycleCount = ccnt_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
   assign InstrCount      = '0;
   assign CycleCount      = '0;
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a program ROM plus a toy decoder drive the DUT, and an
// instruction-level model predicts cycles, strobe counts, final PC and end state.
module tb_cpu_sequencer;
   import cpu_sequencer_pkg::*;

   localparam int TMO = 15;

   logic        Clk = 1'b0;
   logic        Reset, Start, CondFlag, MemReady;
   logic [9:0]  StartAddr, BrTarget, ProgCtr;
   logic [8:0]  Instruction, IR;
   logic        BranchEn, Jump, LoadInst, MemWrEn, RegWrEn, Ack;
   logic        RegWrStrobe, MemRdReq, MemWrStrobe, Busy, Done, TimeoutErr;
   logic [15:0] InstrCount, CycleCount;

   logic [8:0]  rom   [0:1023];
   int          waits [0:1023];
   int          checks = 0, failures = 0;

   cpu_sequencer #(.MEM_TIMEOUT(TMO)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
      .Instruction(Instruction), .BranchEn(BranchEn), .Jump(Jump),
      .LoadInst(LoadInst), .MemWrEn(MemWrEn), .RegWrEn(RegWrEn), .Ack(Ack),
      .CondFlag(CondFlag), .BrTarget(BrTarget), .MemReady(MemReady),
      .ProgCtr(ProgCtr), .IR(IR), .RegWrStrobe(RegWrStrobe), .MemRdReq(MemRdReq),
      .MemWrStrobe(MemWrStrobe), .Busy(Busy), .Done(Done), .TimeoutErr(TimeoutErr),
      .InstrCount(InstrCount), .CycleCount(CycleCount)
   );

   always #5 Clk = ~Clk;

   assign Instruction = rom[ProgCtr];

   // opcode IR[8:6]: 0 alu+write, 1 alu, 2 branch, 3 jump, 4 load, 5 store, 6 jump+branch, 1FF ack
   always_comb begin
      BranchEn = 1'b0; Jump = 1'b0; LoadInst = 1'b0;
      MemWrEn  = 1'b0; RegWrEn = 1'b0; Ack = 1'b0;
      if (IR == kAckInstr) Ack = 1'b1;
      else case (IR[8:6])
         3'd0: RegWrEn  = 1'b1;
         3'd2: BranchEn = 1'b1;
         3'd3: Jump     = 1'b1;
         3'd4: LoadInst = 1'b1;
         3'd5: MemWrEn  = 1'b1;
         3'd6: begin Jump = 1'b1; BranchEn = 1'b1; end
         default: ;
      endcase
   end

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) begin
         rom[i]   = 9'h040;
         waits[i] = 0;
      end
   endtask

   task automatic model(input logic [9:0] sa, output int cyc, output int rw, output int rd,
                        output int wr, output int ni, output logic [9:0] fpc,
                        output bit dn, output bit er);
      logic [9:0] pc;
      logic [8:0] ins;
      int n;
      pc = sa; cyc = 0; rw = 0; rd = 0; wr = 0; ni = 0; dn = 0; er = 0;
      for (int s = 0; s < 200; s++) begin
         ins = rom[pc];
         cyc += 2; ni++;
         if (ins == kAckInstr) begin dn = 1; break; end
         if (ins[8:6] == 3'd4 || ins[8:6] == 3'd5) begin
            n = waits[pc];
            if (n + 1 > TMO) begin
               cyc += TMO;
               if (ins[8:6] == 3'd4) rd += TMO; else wr += TMO;
               er = 1;
               break;
            end
            cyc += n + 1;
            if (ins[8:6] == 3'd4) begin rd += n + 1; cyc += 1; rw++; end
            else wr += n + 1;
            pc = pc + 10'd1;
         end else begin
            if (ins[8:6] == 3'd0) rw++;
            if (ins[8:6] == 3'd3 || ins[8:6] == 3'd6 || (ins[8:6] == 3'd2 && CondFlag))
               pc = BrTarget;
            else
               pc = pc + 10'd1;
         end
      end
      fpc = pc;
   endtask

   // Issues Start, then samples once per cycle (at negedge) until Done or TimeoutErr.
   task automatic run_prog(input logic [9:0] sa, input bit inject, output int cyc,
                           output int rw, output int rd, output int wr,
                           output logic [9:0] fpc, output bit dn, output bit er,
                           output bit clr_ok, output logic [15:0] ic, output logic [15:0] cc);
      int memcnt;
      cyc = 0; rw = 0; rd = 0; wr = 0; memcnt = 0;
      StartAddr = sa; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      clr_ok = Busy && !Done && !TimeoutErr;
      for (int k = 0; k < 3000; k++) begin
         if (Done || TimeoutErr) break;
         if (Busy) cyc++;
         if (RegWrStrobe) rw++;
         if (MemRdReq) rd++;
         if (MemWrStrobe) wr++;
         if (MemRdReq || MemWrStrobe) begin
            memcnt++;
            MemReady = (memcnt == waits[ProgCtr] + 1);
         end else begin
            memcnt = 0;
            MemReady = 1'b0;
         end
         if (inject && k == 2) begin Start = 1'b1; StartAddr = ~sa; end
         else Start = 1'b0;
         @(negedge Clk);
      end
      MemReady = 1'b0; Start = 1'b0;
      fpc = ProgCtr; dn = Done; er = TimeoutErr; ic = InstrCount; cc = CycleCount;
   endtask

   task automatic test_reset();
      Reset = 1'b0; Start = 1'b0; MemReady = 1'b0; CondFlag = 1'b0;
      StartAddr = '0; BrTarget = '0;
      clear_rom();
      repeat (3) @(negedge Clk);
      checks++; if (ProgCtr !== 10'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", ProgCtr); end
      checks++; if (IR !== 9'h000) begin failures++; $display("FAIL reset_ir got=%h exp=000", IR); end
      checks++;
      if ({Busy, Done, TimeoutErr, RegWrStrobe, MemRdReq, MemWrStrobe} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000", {Busy, Done, TimeoutErr, RegWrStrobe, MemRdReq, MemWrStrobe});
      end
      checks++; if ({InstrCount, CycleCount} !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", {InstrCount, CycleCount}); end
      Reset = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_reset_mid_mem();
      clear_rom();
      rom[10'h005] = 9'h100; waits[10'h005] = 100;
      StartAddr = 10'h005; Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      checks++; if (MemRdReq !== 1'b1) begin failures++; $display("FAIL midmem_req got=%b exp=1", MemRdReq); end
      #2 Reset = 1'b0;
      #1;
      checks++; if (MemRdReq !== 1'b0) begin failures++; $display("FAIL midmem_abort got=%b exp=0", MemRdReq); end
      checks++; if (ProgCtr !== 10'h000 || Busy !== 1'b0) begin failures++; $display("FAIL midmem_idle pc=%h busy=%b exp pc=000 busy=0", ProgCtr, Busy); end
      @(negedge Clk); Reset = 1'b1;
      @(negedge Clk); StartAddr = 10'h005; Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
      checks++; if (ProgCtr !== 10'h005 || Busy !== 1'b1) begin failures++; $display("FAIL restart pc=%h busy=%b exp pc=005 busy=1", ProgCtr, Busy); end
      for (int k = 0; k < 40; k++) begin
         if (TimeoutErr) break;
         @(negedge Clk);
      end
      checks++; if (TimeoutErr !== 1'b1 || ProgCtr !== 10'h005) begin failures++; $display("FAIL midmem_tmo err=%b pc=%h exp err=1 pc=005", TimeoutErr, ProgCtr); end
   endtask

   task automatic test_wrap();
      int cyc, rw, rd, wr; logic [9:0] fpc; bit dn, er, ok; logic [15:0] ic, cc;
      clear_rom();
      rom[10'h3FF] = 9'h000; rom[10'h000] = kAckInstr;
      run_prog(10'h3FF, 1'b0, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_start_clear got=%b exp=1", ok); end
      checks++; if (fpc !== 10'h000 || dn !== 1'b1) begin failures++; $display("FAIL wrap_pc pc=%h done=%b exp pc=000 done=1", fpc, dn); end
      checks++; if (cyc != 4 || rw != 1) begin failures++; $display("FAIL wrap_timing cyc=%0d rw=%0d exp cyc=4 rw=1", cyc, rw); end
   endtask

   task automatic test_branch();
      int cyc, rw, rd, wr; logic [9:0] fpc; bit dn, er, ok; logic [15:0] ic, cc;
      clear_rom();
      BrTarget = 10'h120;
      rom[10'h120] = kAckInstr; rom[10'h040] = 9'h080; rom[10'h041] = kAckInstr;
      CondFlag = 1'b0;
      run_prog(10'h040, 1'b0, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
      checks++; if (fpc !== 10'h041 || cyc != 4) begin failures++; $display("FAIL br_not_taken pc=%h cyc=%0d exp pc=041 cyc=4", fpc, cyc); end
      CondFlag = 1'b1;
      run_prog(10'h040, 1'b0, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
      checks++; if (fpc !== 10'h120 || cyc != 4) begin failures++; $display("FAIL br_taken pc=%h cyc=%0d exp pc=120 cyc=4", fpc, cyc); end
      CondFlag = 1'b0; rom[10'h040] = 9'h180;
      run_prog(10'h040, 1'b0, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
      checks++; if (fpc !== 10'h120) begin failures++; $display("FAIL jump_prio pc=%h exp=120", fpc); end
   endtask

   task automatic test_load_store();
      int cyc, rw, rd, wr; logic [9:0] fpc; bit dn, er, ok; logic [15:0] ic, cc, exp_ic, exp_cc;
      clear_rom();
      rom[10'h010] = 9'h100; waits[10'h010] = 3;
      rom[10'h011] = 9'h140; waits[10'h011] = 0;
      rom[10'h012] = kAckInstr;
      run_prog(10'h010, 1'b0, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
      checks++; if (cyc != 12) begin failures++; $display("FAIL ldst_cycles got=%0d exp=12", cyc); end
      checks++; if (rd != 4 || wr != 1 || rw != 1) begin failures++; $display("FAIL ldst_strobes rd=%0d wr=%0d rw=%0d exp 4 1 1", rd, wr, rw); end
      checks++; if (fpc !== 10'h012 || dn !== 1'b1) begin failures++; $display("FAIL ldst_end pc=%h done=%b exp pc=012 done=1", fpc, dn); end
`ifdef SEQ_PERF_CNT_EN
      exp_ic = 16'd3; exp_cc = 16'd12;
`else
      exp_ic = 16'd0; exp_cc = 16'd0;
`endif
      checks++; if (ic !== exp_ic || cc !== exp_cc) begin failures++; $display("FAIL ldst_perf ic=%0d cc=%0d exp ic=%0d cc=%0d", ic, cc, exp_ic, exp_cc); end
   endtask

   task automatic test_timeout();
      int cyc, rw, rd, wr; logic [9:0] fpc; bit dn, er, ok; logic [15:0] ic, cc;
      clear_rom();
      rom[10'h020] = 9'h100; waits[10'h020] = 100; rom[10'h021] = kAckInstr;
      run_prog(10'h020, 1'b0, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
      checks++; if (er !== 1'b1 || fpc !== 10'h020) begin failures++; $display("FAIL tmo_err err=%b pc=%h exp err=1 pc=020", er, fpc); end
      checks++; if (cyc != 17 || rd != 15 || rw != 0) begin failures++; $display("FAIL tmo_cycles cyc=%0d rd=%0d rw=%0d exp 17 15 0", cyc, rd, rw); end
      waits[10'h020] = TMO - 1;
      run_prog(10'h020, 1'b0, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL err_restart_clear got=%b exp=1", ok); end
      checks++; if (er !== 1'b0 || dn !== 1'b1 || cyc != 20 || rw != 1) begin
         failures++; $display("FAIL tmo_edge err=%b done=%b cyc=%0d rw=%0d exp 0 1 20 1", er, dn, cyc, rw);
      end
   endtask

   task automatic test_start_ignored();
      int cyc, rw, rd, wr; logic [9:0] fpc; bit dn, er, ok; logic [15:0] ic, cc;
      clear_rom();
      rom[10'h034] = kAckInstr;
      run_prog(10'h030, 1'b1, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
      checks++; if (fpc !== 10'h034 || cyc != 10 || dn !== 1'b1) begin failures++; $display("FAIL start_busy pc=%h cyc=%0d done=%b exp 034 10 1", fpc, cyc, dn); end
      checks++; if (rw != 0 || rd != 0 || wr != 0 || Busy !== 1'b0) begin failures++; $display("FAIL halt_quiet rw=%0d rd=%0d wr=%0d busy=%b exp all 0", rw, rd, wr, Busy); end
   endtask

   task automatic test_random();
      int cyc, rw, rd, wr, m_cyc, m_rw, m_rd, m_wr, m_ni, k, r;
      logic [9:0] fpc, m_pc, sa; bit dn, er, ok, m_dn, m_er; logic [15:0] ic, cc, exp_ic, exp_cc;
      for (int it = 0; it < 25; it++) begin
         sa = 10'($urandom); BrTarget = 10'($urandom); CondFlag = 1'($urandom);
         k = int'($urandom_range(1, 6));
         for (int i = 0; i < k; i++) begin
            rom[10'(sa + 10'(i))] = {3'($urandom_range(0, 6)), 6'($urandom)};
            r = int'($urandom_range(0, 9));
            waits[10'(sa + 10'(i))] = (r == 0) ? 20 : (r == 1) ? TMO - 1 : int'($urandom_range(0, 4));
         end
         rom[10'(sa + 10'(k))] = kAckInstr;
         rom[BrTarget] = kAckInstr;
         model(sa, m_cyc, m_rw, m_rd, m_wr, m_ni, m_pc, m_dn, m_er);
         run_prog(sa, 1'b0, cyc, rw, rd, wr, fpc, dn, er, ok, ic, cc);
`ifdef SEQ_PERF_CNT_EN
         exp_ic = 16'(m_ni); exp_cc = 16'(m_cyc);
`else
         exp_ic = 16'd0; exp_cc = 16'd0;
`endif
         checks++;
         if (cyc != m_cyc || rw != m_rw || rd != m_rd || wr != m_wr) begin
            failures++;
            $display("FAIL rnd%0d_timing cyc/rw/rd/wr=%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", it, cyc, rw, rd, wr, m_cyc, m_rw, m_rd, m_wr);
         end
         checks++;
         if (fpc !== m_pc || dn !== m_dn || er !== m_er || ok !== 1'b1) begin
            failures++;
            $display("FAIL rnd%0d_end pc=%h done=%b err=%b clr=%b exp pc=%h done=%b err=%b clr=1", it, fpc, dn, er, ok, m_pc, m_dn, m_er);
         end
         checks++;
         if (ic !== exp_ic || cc !== exp_cc) begin
            failures++; $display("FAIL rnd%0d_perf ic=%0d cc=%0d exp ic=%0d cc=%0d", it, ic, cc, exp_ic, exp_cc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_mem();
      test_wrap();
      test_branch();
      test_load_store();
      test_timeout();
      test_start_ignored();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
